exibe_sequencia: RTL and testbench
==================================

Name: exibe_sequencia

Overview:
- Sequence-playback engine for the Genius game. Sits between the control unit and the LED drivers, beside the sequence RAM.
- At each round start it reads RAM entries 0..rodada and lights each stored LED pattern for a difficulty-dependent on-time, followed by an off-gap.
- It then returns a completion pulse so the control unit can move on to waiting for the player.

Parameters:
- ON_TICKS, 1000, base LED on-time in clock cycles (nivel 0).
- OFF_TICKS, 500, base LED off-gap in clock cycles (nivel 0).
- TIMER_W, 16, width of the internal down-counter; must hold max(ON_TICKS, OFF_TICKS).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- iniciar  in  1  start request; sampled only in IDLE
- cancela  in  1  synchronous abort; forces IDLE from any state
- rodada  in  4  index of the last entry to show (0..15)
- nivel  in  2  difficulty: 0 slow, 1 medium, 2/3 fast
- mem_addr  out  4  RAM read address
- mem_data  in  4  RAM read data; synchronous read, valid one cycle after mem_addr
- leds  out  4  LED pattern shown
- ocupado  out  1  high while playback is in progress
- pronto  out  1  one-cycle completion pulse
- db_estado  out  4  state code, for debug

Behaviour:
- Reset values: state IDLE, mem_addr=0, leds=0, ocupado=0, pronto=0, db_estado=0, index and timer registers 0.
- On leaving IDLE, rodada and nivel are captured into registers. Later changes to these inputs are ignored until the next start.
- Timing: on = ON_TICKS >> min(nivel,2); off = OFF_TICKS >> min(nivel,2). Any result of 0 is forced to 1.
- States (db_estado code):
  - IDLE(0): waits. iniciar=1 -> ENDERECA, and idx<=0.
  - ENDERECA(1): mem_addr=idx. Goes to LEITURA.
  - LEITURA(2): mem_data is valid; it is latched into the pattern register. Timer loads on-1. Goes to ACENDE.
  - ACENDE(3): leds=pattern for exactly `on` cycles. When timer==0: load off-1 and go to APAGA; otherwise the timer decrements.
  - APAGA(4): leds=0 for exactly `off` cycles. At timer==0: if idx==rodada_reg go to FIM, else go to PROXIMO.
  - PROXIMO(5): idx<=idx+1. Goes to ENDERECA.
  - FIM(6): pronto=1 for this one cycle. Goes to IDLE.
- leds is nonzero only in ACENDE. It is driven from the state register and pattern register (Moore, registered-state decode).
- ocupado=1 in states 1..5. It is 0 in IDLE and FIM.
- Cycles from the iniciar-sampling edge to the pronto cycle: n*(2+on+off) + (n-1), where n = rodada+1. pronto occupies the following cycle.
- Boundary and abnormal cases:
  - iniciar while not IDLE: ignored.
  - cancela has priority over every transition. The next state is IDLE with leds=0 and no pronto pulse. cancela together with iniciar in IDLE stays in IDLE.
  - rodada=15: all 16 entries are shown; idx does not wrap.
  - A non-one-hot mem_data pattern is displayed unchanged.
  - Reset mid-playback clears everything immediately, asynchronously.

Optional Feature:
- Macro EXIBE_SEQUENCIA_TOM_EN.
- When defined: adds output tom [1:0], the binary index of the lit LED while in ACENDE with a one-hot pattern (0001->0, 0010->1, 0100->2, 1000->3). tom=0 in all other states and for non-one-hot patterns. Adds output tom_en [0:0], high exactly while in ACENDE with a one-hot pattern.
- When not defined: neither port exists and behaviour is otherwise identical.

Decomposition:
- Shared package genius_pkg holds:
  - the state-code localparams (IDLE..FIM, values above);
  - the nivel encodings NIVEL_LENTO=0, NIVEL_MEDIO=1, NIVEL_RAPIDO=2;
  - a function for the shift amount, min(nivel,2).
- One sub-module, contador_tempo: a loadable TIMER_W down-counter with inputs carrega, valor, conta and output zero. It is instantiated once.

Test Plan:
- ON_TICKS=4, OFF_TICKS=2, nivel=0, rodada=0, RAM[0]=0100, pulse iniciar -> mem_addr=0; leds=0100 for exactly 4 cycles starting 2 cycles after the sampling edge, then 0 for 2 cycles; ocupado high 8 cycles; pronto high for 1 cycle on cycle 9.
- rodada=2, RAM={0001,1000,0010}, nivel=1 (on=2, off=1) -> leds shows 0001,1000,0010 in order, each for 2 cycles with 1-cycle gaps; pronto 18 cycles after sampling (n=3: 3*5+2=17 busy cycles).
- nivel=3 with ON_TICKS=2 -> on=max(2>>2,1)=1; each pattern lit for exactly 1 cycle.
- cancela asserted during ACENDE of entry 1 of 3 -> next cycle IDLE, leds=0, ocupado=0, no pronto; a new iniciar restarts from mem_addr=0.
- iniciar re-pulsed mid-playback and rodada changed mid-playback -> no effect; sequence length follows the value captured at start.
- With EXIBE_SEQUENCIA_TOM_EN: RAM[0]=1000 -> tom=3 and tom_en=1 exactly during the lit cycles; RAM[0]=0110 -> tom_en stays 0.

Source files
------------

// File: rtl/genius_pkg.sv
// genius_pkg: shared state codes, difficulty encodings and shift helper for the Genius sequence blocks
package genius_pkg;
  localparam logic [3:0] EST_IDLE     = 4'd0;
  localparam logic [3:0] EST_ENDERECA = 4'd1;
  localparam logic [3:0] EST_LEITURA  = 4'd2;
  localparam logic [3:0] EST_ACENDE   = 4'd3;
  localparam logic [3:0] EST_APAGA    = 4'd4;
  localparam logic [3:0] EST_PROXIMO  = 4'd5;
  localparam logic [3:0] EST_FIM      = 4'd6;
  typedef enum logic [3:0] {
    IDLE     = EST_IDLE,
    ENDERECA = EST_ENDERECA,
    LEITURA  = EST_LEITURA,
    ACENDE   = EST_ACENDE,
    APAGA    = EST_APAGA,
    PROXIMO  = EST_PROXIMO,
    FIM      = EST_FIM
  } estado_t;
  localparam logic [1:0] NIVEL_LENTO  = 2'd0;
  localparam logic [1:0] NIVEL_MEDIO  = 2'd1;
  localparam logic [1:0] NIVEL_RAPIDO = 2'd2;
  // Shift applied to the base timings: min(nivel, 2); levels 2 and 3 are both "fast".
  function automatic logic [1:0] deslocamento(input logic [1:0] nivel);
    return (nivel >= NIVEL_RAPIDO) ? NIVEL_RAPIDO : ((nivel == NIVEL_MEDIO) ? NIVEL_MEDIO : NIVEL_LENTO);
  endfunction
endpackage

// File: rtl/exibe_sequencia_contador_tempo.sv
// contador_tempo: loadable down-counter that stops at zero
//   clock, reset : clock, asynchronous active-high reset
//   carrega      : load valor (has priority over conta)
//   valor        : load value
//   conta        : decrement while nonzero
//   zero         : count is zero
module contador_tempo #(
  parameter int TIMER_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               carrega,
  input  logic [TIMER_W-1:0] valor,
  input  logic               conta,
  output logic               zero
);
  logic [TIMER_W-1:0] contagem;
  always_ff @(posedge clock or posedge reset)
    if (reset) contagem <= '0;
    else if (carrega) contagem <= valor;
    else if (conta && !zero) contagem <= contagem - TIMER_W'(1);
  assign zero = contagem == '0;
endmodule

// File: rtl/exibe_sequencia.sv
// exibe_sequencia: plays RAM entries 0..rodada on the LEDs with difficulty-dependent on/off times
//   clock, reset : clock, asynchronous active-high reset
//   iniciar      : start request, sampled only in IDLE
//   cancela      : synchronous abort back to IDLE
//   rodada       : index of the last entry to show
//   nivel        : difficulty (0 slow, 1 medium, 2/3 fast)
//   mem_addr     : RAM read address; mem_data: RAM data, valid one cycle after mem_addr
//   leds         : pattern shown; ocupado: playback in progress; pronto: completion pulse
//   db_estado    : state code
//   Optional (EXIBE_SEQUENCIA_TOM_EN): tom = index of the lit LED, tom_en = one-hot pattern lit
module exibe_sequencia
  import genius_pkg::*;
#(
  parameter int ON_TICKS  = 1000,
  parameter int OFF_TICKS = 500,
  parameter int TIMER_W   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       cancela,
  input  logic [3:0] rodada,
  input  logic [1:0] nivel,
  output logic [3:0] mem_addr,
  input  logic [3:0] mem_data,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       pronto,
`ifdef EXIBE_SEQUENCIA_TOM_EN
  output logic [1:0] tom,
  output logic [0:0] tom_en,
`endif
  output logic [3:0] db_estado
);
  localparam logic [TIMER_W-1:0] ON_BASE  = TIMER_W'(ON_TICKS);
  localparam logic [TIMER_W-1:0] OFF_BASE = TIMER_W'(OFF_TICKS);
  estado_t            estado;
  logic [3:0]         idx, rodadaReg, padrao;
  logic [1:0]         nivelReg;
  logic [TIMER_W-1:0] onBruto, offBruto, tOn, tOff, valor;
  logic               carrega, conta, zero;
  assign onBruto  = ON_BASE >> deslocamento(nivelReg);
  assign offBruto = OFF_BASE >> deslocamento(nivelReg);
  assign tOn      = (onBruto == '0) ? TIMER_W'(1) : onBruto;
  assign tOff     = (offBruto == '0) ? TIMER_W'(1) : offBruto;
  // The counter is loaded with length-1 on the cycle before each phase, so a phase
  // lasts exactly its length and ends on the cycle the counter reads zero.
  always_comb begin
    carrega = (estado == LEITURA) || (estado == ACENDE && zero);
    valor   = (estado == LEITURA) ? tOn - TIMER_W'(1) : tOff - TIMER_W'(1);
    conta   = (estado == ACENDE) || (estado == APAGA);
  end
  contador_tempo #(.TIMER_W(TIMER_W)) uTempo (
    .clock  (clock),
    .reset  (reset),
    .carrega(carrega),
    .valor  (valor),
    .conta  (conta),
    .zero   (zero)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      estado    <= IDLE;
      idx       <= '0;
      rodadaReg <= '0;
      nivelReg  <= NIVEL_LENTO;
      padrao    <= '0;
    end else if (cancela) begin
      estado <= IDLE;
    end else begin
      case (estado)
        IDLE: if (iniciar) begin
          estado    <= ENDERECA;
          idx       <= '0;
          rodadaReg <= rodada;
          nivelReg  <= nivel;
        end
        ENDERECA: estado <= LEITURA;
        LEITURA: begin
          padrao <= mem_data;
          estado <= ACENDE;
        end
        ACENDE:  if (zero) estado <= APAGA;
        APAGA:   if (zero) estado <= (idx == rodadaReg) ? FIM : PROXIMO;
        PROXIMO: begin
          idx    <= idx + 4'd1;
          estado <= ENDERECA;
        end
        FIM:     estado <= IDLE;
        default: estado <= IDLE;
      endcase
    end
  assign mem_addr  = idx;
  assign leds      = (estado == ACENDE) ? padrao : 4'd0;
  assign ocupado   = (estado != IDLE) && (estado != FIM);
  assign pronto    = estado == FIM;
  assign db_estado = estado;
`ifdef EXIBE_SEQUENCIA_TOM_EN
  logic umQuente;
  assign umQuente = (padrao != 4'd0) && ((padrao & (padrao - 4'd1)) == 4'd0);
  assign tom_en   = (estado == ACENDE) && umQuente;
  assign tom      = tom_en ? {padrao[3] | padrao[2], padrao[3] | padrao[1]} : 2'd0;
`endif
endmodule

// File: tb/tb_exibe_sequencia.sv
// tb_exibe_sequencia: randomized and directed checks of exibe_sequencia against a cycle-list model
module tb_exibe_sequencia;
  localparam int ON = 4;
  localparam int OFF = 2;
  logic clock = 0, reset = 1, iniciar = 0, cancela = 0;
  logic [3:0] rodada = 0, mem_addr, memData = 0, leds, db_estado;
  logic [1:0] nivel = 0;
  logic ocupado, pronto;
  logic [3:0] ram [16];
`ifdef EXIBE_SEQUENCIA_TOM_EN
  logic [1:0] tom;
  logic [0:0] tom_en;
  int tomCnt = 0;
`endif
  exibe_sequencia #(.ON_TICKS(ON), .OFF_TICKS(OFF), .TIMER_W(8)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .cancela(cancela),
    .rodada(rodada), .nivel(nivel), .mem_addr(mem_addr), .mem_data(memData),
    .leds(leds), .ocupado(ocupado), .pronto(pronto),
`ifdef EXIBE_SEQUENCIA_TOM_EN
    .tom(tom), .tom_en(tom_en),
`endif
    .db_estado(db_estado));
  always #5 clock = ~clock;
  always @(posedge clock) memData <= ram[mem_addr];

  typedef struct packed {logic [3:0] l; logic o; logic p; logic [3:0] e; logic [3:0] a;} rec_t;
  rec_t q[$];
  int errors = 0, checks = 0;
  logic [3:0] curLeds, curEst;
  logic curOc, curPr;
  logic [3:0] litSeq[$];

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic rec_t mk(input logic [3:0] l, input logic o, input logic p, input logic [3:0] e, input logic [3:0] a);
    return {l, o, p, e, a};
  endfunction

  // Expected cycle-by-cycle outputs of one full playback, from the timing rules.
  task automatic gen();
    int n, sh, on, off;
    n = int'(rodada) + 1;
    sh = (nivel > 2) ? 2 : int'(nivel);
    on = ON >> sh;
    off = OFF >> sh;
    if (on == 0) on = 1;
    if (off == 0) off = 1;
    for (int i = 0; i < n; i++) begin
      q.push_back(mk(0, 1, 0, 1, 4'(i)));
      q.push_back(mk(0, 1, 0, 2, 4'(i)));
      repeat (on) q.push_back(mk(ram[i], 1, 0, 3, 4'(i)));
      repeat (off) q.push_back(mk(0, 1, 0, 4, 4'(i)));
      if (i < n - 1) q.push_back(mk(0, 1, 0, 5, 4'(i)));
    end
    q.push_back(mk(0, 0, 1, 6, 4'(n - 1)));
  endtask

  function automatic int tomEsp(input logic [3:0] p);
    case (p)
      4'b0001: return 4;
      4'b0010: return 5;
      4'b0100: return 6;
      4'b1000: return 7;
      default: return 0;
    endcase
  endfunction

  // One clock: compare at the falling edge, advance the model with the inputs the next rising edge samples.
  task automatic tick();
    rec_t x;
    bit wasIdle;
    @(negedge clock);
    if (reset) q.delete();
    x = (q.size() != 0) ? q[0] : mk(0, 0, 0, 0, 0);
    chk("leds", leds, x.l);
    chk("ocupado", ocupado, x.o);
    chk("pronto", pronto, x.p);
    chk("db_estado", db_estado, x.e);
    if (x.e == 1 || reset) chk("mem_addr", mem_addr, x.a);
`ifdef EXIBE_SEQUENCIA_TOM_EN
    begin
      int t;
      t = (x.e == 3) ? tomEsp(x.l) : 0;
      chk("tom_en", tom_en, t >> 2);
      chk("tom", tom, t & 3);
      if (tom_en) tomCnt++;
    end
`endif
    curLeds = leds; curOc = ocupado; curPr = pronto; curEst = db_estado;
    if (!reset) begin
      wasIdle = q.size() == 0;
      if (!wasIdle) void'(q.pop_front());
      if (cancela) q.delete();
      else if (wasIdle && iniciar) gen();
    end
    @(posedge clock);
    #1;
  endtask

  task automatic run(input int mexe, input int canc, input int lim, output int prAt, output int lit, output int busy);
    prAt = -1; lit = 0; busy = 0;
    litSeq.delete();
    iniciar = 1;
    tick();
    iniciar = 0;
    for (int k = 1; k <= lim && prAt < 0; k++) begin
      if (k == mexe) begin iniciar = 1; rodada = 15; end
      else iniciar = 0;
      cancela = (k == canc);
      tick();
      if (curLeds != 0) begin lit++; litSeq.push_back(curLeds); end
      if (curOc) busy++;
      if (curPr) prAt = k;
    end
    iniciar = 0;
    cancela = 0;
  endtask

  initial begin
    int pr, lit, busy;
    for (int i = 0; i < 16; i++) ram[i] = 4'(i + 1);
    tick();
    chk("reset_estado", curEst, 0);
    chk("reset_ocupado", curOc, 0);
    reset = 0;
    tick();
    // single entry, slow
    ram[0] = 4'b0100; rodada = 0; nivel = 0;
    run(0, 0, 50, pr, lit, busy);
    chk("t1_pronto_ciclo", pr, 9);
    chk("t1_aceso", lit, 4);
    chk("t1_ocupado", busy, 8);
    // three entries, medium
    ram[0] = 4'b0001; ram[1] = 4'b1000; ram[2] = 4'b0010; rodada = 2; nivel = 1;
    run(0, 0, 80, pr, lit, busy);
    chk("t2_pronto_ciclo", pr, 18);
    chk("t2_aceso", lit, 6);
    chk("t2_ocupado", busy, 17);
    if (litSeq.size() == 6) begin
      chk("t2_seq0", litSeq[0], 1);
      chk("t2_seq2", litSeq[2], 8);
      chk("t2_seq4", litSeq[4], 2);
    end else chk("t2_seq_tamanho", litSeq.size(), 6);
    // nivel 3: both timings shrink to the 1-cycle floor
    rodada = 1; nivel = 3;
    run(0, 0, 50, pr, lit, busy);
    chk("t3_pronto_ciclo", pr, 10);
    chk("t3_aceso", lit, 2);
    // cancel during ACENDE of entry 1
    rodada = 2; nivel = 0;
    run(0, 13, 40, pr, lit, busy);
    chk("t4_sem_pronto", pr, -1);
    chk("t4_aceso", lit, 6);
    chk("t4_ocupado", busy, 13);
    // cancela together with iniciar in IDLE
    cancela = 1; iniciar = 1;
    tick();
    cancela = 0; iniciar = 0;
    tick();
    chk("t4_cancela_idle", curOc, 0);
    // iniciar re-pulse and rodada change mid-playback
    rodada = 1; nivel = 2;
    run(3, 0, 50, pr, lit, busy);
    chk("t5_pronto_ciclo", pr, 10);
    chk("t5_aceso", lit, 2);
    // all 16 entries
    for (int i = 0; i < 16; i++) ram[i] = 4'($urandom_range(1, 15));
    rodada = 15; nivel = 2;
    run(0, 0, 200, pr, lit, busy);
    chk("t6_pronto_ciclo", pr, 80);
    chk("t6_aceso", lit, 16);
    chk("t6_ocupado", busy, 79);
    // asynchronous reset mid-playback
    rodada = 3; nivel = 0;
    run(0, 0, 5, pr, lit, busy);
    reset = 1;
    tick();
    chk("t7_reset_estado", curEst, 0);
    chk("t7_reset_leds", curLeds, 0);
    reset = 0;
    tick();
`ifdef EXIBE_SEQUENCIA_TOM_EN
    ram[0] = 4'b1000; rodada = 0; nivel = 0; tomCnt = 0;
    run(0, 0, 50, pr, lit, busy);
    chk("tom_ciclos_um_quente", tomCnt, 4);
    ram[0] = 4'b0110; tomCnt = 0;
    run(0, 0, 50, pr, lit, busy);
    chk("tom_ciclos_nao_um_quente", tomCnt, 0);
`endif
    // randomized playbacks, with occasional aborts and ignored restarts
    repeat (30) begin
      for (int i = 0; i < 16; i++) ram[i] = 4'($urandom_range(0, 15));
      rodada = 4'($urandom_range(0, 15));
      nivel = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 3)) tick();
      run(($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 60)) : 0,
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : 0,
          200, pr, lit, busy);
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
